// File: rtl/sum_responder.sv
// sum_responder
//   Callee-side endpoint for the "sum" call interface. Each accepted request
//   (a, b, tag) produces o1 = a+b and o2 = a+b+1. The results and the tag are
//   queued in a small result FIFO and returned in acceptance order, so caller
//   back-pressure on the response side does not stall request acceptance until
//   the FIFO fills.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   req_valid   caller presents a call
//   req_ready   a call can be accepted this cycle (depends only on FIFO fill)
//   req_a/req_b operands, WIDTH bits, unsigned
//   req_tag     caller tag, returned unmodified
//   rsp_valid   a result is at the FIFO head
//   rsp_ready   caller consumes the head result this cycle
//   rsp_o1      a+b, WIDTH+1 bits
//   rsp_o2      a+b+1, WIDTH+1 bits
//   rsp_tag     tag of the returned call
//   calls_done  completed response handshakes (saturating)
//
// Build option
//   SUM_RESPONDER_STATS_EN  when defined, calls_done counts response handshakes
//                           and saturates at 16'hFFFF; otherwise it reads 0.
module sum_responder #(
  parameter int WIDTH = 2,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_o1,
  output logic [WIDTH:0]   rsp_o2,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      calls_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH:0]   mem_o1  [DEPTH];
  logic [WIDTH:0]   mem_o2  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic           accept;
  logic           pop;
  logic [WIDTH:0] sum_o1;
  logic [WIDTH:0] sum_o2;

  // req_ready is a function of count only, so rsp_ready never reaches it
  // combinationally; a pop while full frees a slot only from the next cycle.
  assign req_ready = (count != FULL);
  assign rsp_valid = (count != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Zero-extend before adding; a+b+1 always fits in WIDTH+1 bits.
  assign sum_o1 = {1'b0, req_a} + {1'b0, req_b};
  assign sum_o2 = sum_o1 + 1'b1;

  // Head entry is read straight from storage; it cannot change while it is
  // the head and not popped, so the outputs are stable under back-pressure.
  assign rsp_o1  = mem_o1[rd_ptr];
  assign rsp_o2  = mem_o2[rd_ptr];
  assign rsp_tag = mem_tag[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_o1[i]  <= '0;
        mem_o2[i]  <= '0;
        mem_tag[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_o1[wr_ptr]  <= sum_o1;
        mem_o2[wr_ptr]  <= sum_o2;
        mem_tag[wr_ptr] <= req_tag;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SUM_RESPONDER_STATS_EN
  logic [15:0] calls_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      calls_q <= '0;
    end else if (pop && (calls_q != 16'hFFFF)) begin
      calls_q <= calls_q + 16'd1;
    end
  end

  assign calls_done = calls_q;
`else
  assign calls_done = 16'h0000;
`endif

endmodule

// File: tb/tb_sum_responder.sv
module tb_sum_responder;

  localparam int WIDTH = 2;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

`ifdef SUM_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_o1;
  logic [WIDTH:0]   rsp_o2;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      calls_done;

  sum_responder #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_o1     (rsp_o1),
    .rsp_o2     (rsp_o2),
    .rsp_tag    (rsp_tag),
    .calls_done (calls_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH:0]   o1;
    logic [WIDTH:0]   o2;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: compares every response handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_o1", 32'(rsp_o1), 32'(e.o1));
          check("rsp_o2", 32'(rsp_o2), 32'(e.o2));
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge,
  // leaving req_valid asserted so calls can run back to back.
  task automatic issue(input int a, input int b, input int tag,
                       input int e1, input int e2, output int waited);
    exp_t e;
    waited    = 0;
    req_valid = 1'b1;
    req_a     = WIDTH'(a);
    req_b     = WIDTH'(b);
    req_tag   = TAG_W'(tag);
    forever begin
      @(negedge clock);
      if (req_ready) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    e.o1  = (WIDTH+1)'(e1);
    e.o2  = (WIDTH+1)'(e2);
    e.tag = TAG_W'(tag);
    exp_q.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  int w;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_o1", 32'(rsp_o1), 32'd0);
    check("rst_o2", 32'(rsp_o2), 32'd0);
    check("rst_tag", 32'(rsp_tag), 32'd0);
    check("rst_calls_done", 32'(calls_done), 32'd0);
    @(posedge clock); #1;

    // Single call with exact one-cycle latency
    rsp_ready = 1'b1;
    issue(3, 3, 5, 6, 7, w);
    idle();
    @(negedge clock);
    check("latency_valid", 32'(rsp_valid), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("single_empty_after_pop", 32'(rsp_valid), 32'd0);
    @(posedge clock); #1;

    // Zero operands
    issue(0, 0, 6, 0, 1, w);
    issue(3, 0, 7, 3, 4, w);
    idle();
    drain();

    // Fill and back-pressure
    rsp_ready = 1'b0;
    issue(1, 1, 1, 2, 3, w);
    issue(2, 1, 2, 3, 4, w);
    issue(3, 1, 3, 4, 5, w);
    issue(0, 1, 4, 1, 2, w);
    check("fill_no_stall", 32'(w), 32'd0);
    req_a = 2'd1; req_b = 2'd1; req_tag = 4'd5;  // tag 5 held while full
    @(negedge clock);
    check("full_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("full_hold_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("full_pop_no_accept", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    issue(1, 1, 5, 2, 3, w);
    check("ready_after_first_pop", 32'(w), 32'd0);
    idle();
    drain();
    check("calls_done_8", 32'(calls_done), STATS ? 32'd8 : 32'd0);

    // Streaming, 16 back-to-back calls, pointers wrap four times
    for (int i = 0; i < 16; i++) begin
      issue(i % 4, (i / 4) % 4, i, (i % 4) + ((i / 4) % 4), (i % 4) + ((i / 4) % 4) + 1, w);
      check("stream_no_stall", 32'(w), 32'd0);
    end
    idle();
    drain();
    check("calls_done_24", 32'(calls_done), STATS ? 32'd24 : 32'd0);

    // Reset mid-operation
    rsp_ready = 1'b0;
    issue(1, 2, 9, 3, 4, w);
    issue(2, 2, 10, 4, 5, w);
    issue(3, 3, 11, 6, 7, w);
    reset     = 1'b1;
    req_a     = 2'd1;
    req_b     = 2'd1;
    req_tag   = 4'd13;    // handshake attempts in the reset cycle must vanish
    rsp_ready = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clock);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_calls_done", 32'(calls_done), 32'd0);
    check("mid_rst_o1", 32'(rsp_o1), 32'd0);
    check("mid_rst_tag", 32'(rsp_tag), 32'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    issue(2, 1, 12, 3, 4, w);
    idle();
    drain();
    @(negedge clock);
    check("post_rst_empty", 32'(rsp_valid), 32'd0);
    check("calls_done_after_rst", 32'(calls_done), STATS ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sum_responder.md
# sum_responder

Callee-side endpoint for the `sum` function-call interface. It accepts call requests carrying two unsigned operands and a caller tag over a valid/ready channel. It computes `o1 = a + b` and `o2 = a + b + 1`, then returns both results with the same tag over a second valid/ready channel. An internal result FIFO decouples caller back-pressure from request acceptance, so several calls can be in flight.

## Interface
Parameters:
- `WIDTH`, 2, operand width; results are `WIDTH+1` bits.
- `TAG_W`, 4, caller tag width; the tag is returned unmodified.
- `DEPTH`, 4, result FIFO entries; must be a power of two, at least 2.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  caller presents a call.
- `req_ready`  out  1  responder can accept a call this cycle.
- `req_a`  in  WIDTH  operand a.
- `req_b`  in  WIDTH  operand b.
- `req_tag`  in  TAG_W  caller tag.
- `rsp_valid`  out  1  result available at FIFO head.
- `rsp_ready`  in  1  caller consumes the result this cycle.
- `rsp_o1`  out  WIDTH+1  a+b.
- `rsp_o2`  out  WIDTH+1  a+b+1.
- `rsp_tag`  out  TAG_W  tag of the returned call.
- `calls_done`  out  16  count of completed response handshakes (see Configuration).

## Operation
- Request accept: `req_valid && req_ready` at a rising edge.
- On accept, the responder computes `{o1, o2, tag}` and writes it to the FIFO slot at `wr_ptr`. `wr_ptr` increments mod DEPTH.
- Arithmetic is unsigned. Each operand is zero-extended to WIDTH+1 before adding. `a+b+1` never exceeds 2^(WIDTH+1)-1, so no truncation occurs.
- Response pop: `rsp_valid && rsp_ready` at a rising edge. `rd_ptr` increments mod DEPTH.
- `count` (log2(DEPTH)+1 bits):
  - accept only: +1
  - pop only: -1
  - both in the same cycle: unchanged
- `rsp_valid = (count != 0)`. `rsp_o1`, `rsp_o2` and `rsp_tag` reflect the head entry and are held stable while `rsp_valid && !rsp_ready`.
- `req_ready = (count != DEPTH)`. There is no combinational path from `rsp_ready` to `req_ready`. When the FIFO is full, a simultaneous pop does not enable an accept that cycle.
- Responses return in acceptance order.
- Data outputs are don't-care while `rsp_valid = 0`. The bench must not check them then.

## Timing
- Reset values:
  - `req_ready = 1`, `rsp_valid = 0`, `count = 0`, pointers 0, `calls_done = 0`.
  - `rsp_o1`, `rsp_o2` and `rsp_tag` read 0 after reset.
- Latency: a request accepted at edge N with an empty FIFO gives `rsp_valid = 1` in the cycle following edge N. There is no same-cycle bypass.
- Throughput: one call per cycle sustained when `rsp_ready` is held high.
- Full: after DEPTH accepts with no pops, `req_ready = 0` until the cycle after the first pop.
- Empty with a simultaneous accept and no pop: `count` goes 0→1.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no gap or duplicate entry.
- Reset mid-operation: all in-flight results are discarded, and all outputs return to their reset values at the next edge. Handshakes in the reset cycle have no effect.

## Configuration
- Macro: `SUM_RESPONDER_STATS_EN`.
- Defined: `calls_done` increments by 1 on every response handshake and saturates at 16'hFFFF.
- Undefined: the counter logic is not built and `calls_done` is tied to 16'h0000. The port list is identical in both builds.

## Test plan
- Single call: `a=3, b=3, tag=5` after reset → exactly one cycle later `rsp_valid=1`, `o1=6`, `o2=7`, `tag=5`. With `rsp_ready=1` it pops, and `rsp_valid=0` next cycle.
- Zero operands: `a=0, b=0` → `o1=0`, `o2=1`. Then `a=3, b=0` → `o1=3`, `o2=4`.
- Fill and back-pressure: `rsp_ready=0`, issue 5 calls with tags 1..5 → tags 1..4 accepted and `req_ready=0` with tag 5 held. Raise `rsp_ready` → tags 1,2,3,4,5 return in order. `req_ready` rises the cycle after the first pop.
- Streaming: 16 back-to-back calls with `rsp_ready=1` and `a=i%4, b=(i/4)%4` → one response per cycle with correct sums, and the pointers wrap 4 times.
- Reset mid-operation: 3 entries queued, assert `reset` for 1 cycle → `rsp_valid=0`, `req_ready=1`, `calls_done=0`. The next call returns correctly with no stale entries.
- Stats: with the macro defined, 10 completed handshakes → `calls_done=10`. With it undefined → `calls_done=0`.
